// File: rtl/aes_128_inv_round.sv
// Iterative AES-128 inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Byte-serial by default; define AES_INV_ROUND_FAST_EN for the column-parallel datapath.
`timescale 1ns/1ps
module aes_128_inv_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

`ifdef AES_INV_ROUND_FAST_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (9, b, d or e) using the doubling chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? a2 : 8'h00) ^ (m[2] ? a4 : 8'h00) ^ (m[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  state_t           state, state_next;
  logic [7:0]       st [16];
  logic [7:0]       st_next [16];
  logic [7:0]       key [16];
  logic [7:0]       key_next [16];
  logic [7:0]       in_shift [16];
  logic [7:0]       in_key_b [16];
  logic             last, last_next;
  logic [CNT_W-1:0] cnt, cnt_next;
`ifndef AES_INV_ROUND_FAST_EN
  logic [1:0]       col, col_next;
`endif

  // Byte i sits at row i%4, column i/4; InvShiftRows moves row r right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign in_shift[4*((c+r)%4)+r]           = in_state[127-8*(4*c+r) -: 8];
      assign in_key_b[4*c+r]                   = in_key[127-8*(4*c+r) -: 8];
      assign out_state[127-8*(4*c+r) -: 8]     = st[4*c+r];
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SUB;
      end
      SUB: if (cnt == CNT_MAX) state_next = last ? DONE : MIX;
`ifdef AES_INV_ROUND_FAST_EN
      MIX: state_next = DONE;
`else
      MIX: if (col == 2'd3) state_next = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    st_next   = st;
    key_next  = key;
    last_next = last;
    cnt_next  = cnt;
`ifndef AES_INV_ROUND_FAST_EN
    col_next  = col;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_next   = in_shift;
          key_next  = in_key_b;
          last_next = in_last;
          cnt_next  = '0;
`ifndef AES_INV_ROUND_FAST_EN
          col_next  = '0;
`endif
        end
      end
      SUB: begin
`ifdef AES_INV_ROUND_FAST_EN
        for (int r = 0; r < 4; r++) begin
          st_next[{cnt, 2'(r)}] = INV_SBOX[st[{cnt, 2'(r)}]] ^ key[{cnt, 2'(r)}];
        end
`else
        st_next[cnt] = INV_SBOX[st[cnt]] ^ key[cnt];
`endif
        cnt_next = cnt + 1'b1;
      end
      MIX: begin
`ifdef AES_INV_ROUND_FAST_EN
        for (int c = 0; c < 4; c++) begin
          {st_next[4'(4*c)], st_next[4'(4*c+1)], st_next[4'(4*c+2)], st_next[4'(4*c+3)]} =
            inv_mix({st[4'(4*c)], st[4'(4*c+1)], st[4'(4*c+2)], st[4'(4*c+3)]});
        end
`else
        {st_next[{col, 2'd0}], st_next[{col, 2'd1}], st_next[{col, 2'd2}], st_next[{col, 2'd3}]} =
          inv_mix({st[{col, 2'd0}], st[{col, 2'd1}], st[{col, 2'd2}], st[{col, 2'd3}]});
        col_next = col + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '{default: 8'h00};
      key   <= '{default: 8'h00};
      last  <= 1'b0;
      cnt   <= '0;
`ifndef AES_INV_ROUND_FAST_EN
      col   <= '0;
`endif
    end else begin
      state <= state_next;
      st    <= st_next;
      key   <= key_next;
      last  <= last_next;
      cnt   <= cnt_next;
`ifndef AES_INV_ROUND_FAST_EN
      col   <= col_next;
`endif
    end
  end

endmodule

// File: tb/tb_aes_128_inv_round.sv
// Self-checking bench for aes_128_inv_round: a FIPS-197 reference model with its own
// S-box derivation, a per-cycle compare process, directed vectors and random traffic.
`timescale 1ns/1ps
module tb_aes_128_inv_round;

`ifdef AES_INV_ROUND_FAST_EN
  localparam int LAT_LAST = 4;
  localparam int LAT_FULL = 5;
`else
  localparam int LAT_LAST = 16;
  localparam int LAT_FULL = 20;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  typedef struct {
    logic [127:0] res;
    int           done;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_accept = 0;
  logic [7:0] isb [256];

  aes_128_inv_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Shift-and-add multiply in GF(2^8) mod 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Forward S-box from multiplicative inverse plus affine map, then inverted.
  task automatic build_inv_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   kb [16];
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 16; i++) begin
      a[i]  = s[127-8*i -: 8];
      kb[i] = k[127-8*i -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*((c+r)%4)+r] = a[4*c+r];
    for (int i = 0; i < 16; i++) t[i] = isb[t[i]] ^ kb[i];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int kk = 0; kk < 4; kk++) acc = acc ^ gf_mul(m[(kk-j+4)%4], t[4*c+kk]);
        a[4*c+j] = last ? t[4*c+j] : acc;
      end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = a[i];
    return res;
  endfunction

  // Compare process: outstanding requests define ready, valid timing and the result.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
      checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
      checkOutput("reset_out_state", out_state, 128'(0));
    end else begin
      if (q.size() == 0) begin
        checkOutput("in_ready_idle", 128'(in_ready), 128'(1));
        checkOutput("out_valid_idle", 128'(out_valid), 128'(0));
      end else begin
        checkOutput("in_ready_busy", 128'(in_ready), 128'(0));
        checkOutput("out_valid_timing", 128'(out_valid), 128'(cyc >= q[0].done));
        if (cyc >= q[0].done) checkOutput("out_state", out_state, q[0].res);
        if (out_valid && out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] s, input logic [127:0] k, input logic last,
                               input int hold, input bit tie);
    int   n;
    exp_t e;
    in_state  = s;
    in_key    = k;
    in_last   = last;
    in_valid  = 1'b1;
    out_ready = tie;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.res  = model_round(s, k, last);
    e.done = cyc + (last ? LAT_LAST : LAT_FULL);
    q.push_back(e);
    last_accept = cyc;
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkOutput("result_timeout", 128'(out_valid), 128'(1));
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!tie) out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] rs, rk;
    logic         rl;
    int           prev_acc;
    int           prev_lat;
    in_valid  = 1'b0;
    in_state  = '0;
    in_key    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    build_inv_sbox();

    checkOutput("model_zero_last", model_round('0, '0, 1'b1), {16{8'h52}});
    checkOutput("model_zero_mix", model_round('0, '0, 1'b0), {16{8'h52}});
    checkOutput("model_key_add", model_round('0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1),
                128'h52535051565754555a5b58595e5f5c5d);
    checkOutput("model_shift_rows", model_round(128'h637c6363636363636363636363636363, '0, 1'b1),
                128'h00000000000100000000000000000000);
    checkOutput("model_mix_cols", model_round(128'h7c636363636363636363636363636363, '0, 1'b0),
                128'h0e090d0b000000000000000000000000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus('0, '0, 1'b1, 0, 1'b0);
    applyStimulus('0, '0, 1'b0, 0, 1'b0);
    applyStimulus('0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1, 1'b0);
    applyStimulus(128'h637c6363636363636363636363636363, '0, 1'b1, 0, 1'b0);
    applyStimulus(128'h7c636363636363636363636363636363, '0, 1'b0, 10, 1'b0);

    $display("[TB] reset during SUB");
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    begin
      exp_t e;
      e.res  = model_round(in_state, in_key, in_last);
      e.done = cyc + LAT_FULL;
      q.push_back(e);
    end
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    checkOutput("async_reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("async_reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("async_reset_out_state", out_state, 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(128'h7c636363636363636363636363636363, '0, 1'b0, 0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rl = 1'($urandom_range(0, 1));
      applyStimulus(rs, rk, rl, $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] back-to-back with out_ready high");
    prev_acc = -1;
    prev_lat = 0;
    for (int i = 0; i < 6; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rl = 1'($urandom_range(0, 1));
      applyStimulus(rs, rk, rl, 0, 1'b1);
      if (prev_acc >= 0) checkOutput("throughput_interval", 128'(last_accept - prev_acc), 128'(prev_lat + 2));
      prev_acc = last_accept;
      prev_lat = rl ? LAT_LAST : LAT_FULL;
    end
    out_ready = 1'b0;

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
